// File: rtl/diff_scan_ctrl.sv
// Sequential lowest-differing-bit scanner: streams every set bit index of a^b,
// lowest first, over valid/ready, and reports the first index and a transfer count.
module diff_scan_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        idx_valid,
    output logic [5:0]  idx,
    input  logic        idx_ready,
    output logic [5:0]  first_idx,
    output logic [5:0]  diff_count,
    output logic        done
);

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   pend, pend_nx;
    logic [IDX_W-1:0]   first_q, first_nx;
    logic [IDX_W-1:0]   count_q, count_nx;
    logic               busy_q, valid_q, done_q;

    logic [WIDTH-1:0]   diff_c;
    logic [IDX_W-1:0]   idx_c;
    logic [IDX_W-1:0]   first_c;
    logic               last_c;

    assign diff_c = a ^ b;
    assign last_c = ((pend & (pend - 32'd1)) == '0);

    // Lowest set bit of pend, i.e. encode(pend & -pend); 0 when pend is empty.
    always_comb begin
        idx_c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) idx_c = IDX_W'(i);
        end
    end

    // Lowest set bit of the incoming operands' XOR; WIDTH when they are equal.
    always_comb begin
        first_c = IDX_W'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (diff_c[i]) first_c = IDX_W'(i);
        end
    end

    // Next-state and datapath update; abort outranks a pending transfer.
    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        first_nx = first_q;
        count_nx = count_q;
        case (state)
            IDLE: begin
                if (start) begin
                    pend_nx  = diff_c;
                    count_nx = '0;
                    first_nx = first_c;
                    state_nx = (diff_c != '0) ? EMIT : FIN;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_nx = IDLE;
                    pend_nx  = '0;
                end else if (idx_ready) begin
                    pend_nx  = pend & (pend - 32'd1);
                    count_nx = count_q + 6'd1;
                    if (last_c) state_nx = FIN;
                end
            end
            FIN: begin
                state_nx = IDLE;
                if (abort) pend_nx = '0;
            end
            default: begin
                state_nx = IDLE;
                pend_nx  = '0;
            end
        endcase
    end

    // State, datapath and status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= '0;
            first_q <= IDX_W'(WIDTH);
            count_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            first_q <= first_nx;
            count_q <= count_nx;
            busy_q  <= (state_nx != IDLE);
            valid_q <= (state_nx == EMIT);
            done_q  <= (state_nx == FIN);
        end
    end

    assign busy       = busy_q;
    assign idx_valid  = valid_q;
    assign idx        = idx_c;
    assign first_idx  = first_q;
    assign diff_count = count_q;
    assign done       = done_q;

endmodule
